// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcode encodings, opcode field position and the
// fetch-sequencer state encoding.
package lc2k_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_NOR  = 3'b001,
    OP_LW   = 3'b010,
    OP_SW   = 3'b011,
    OP_BEQ  = 3'b100,
    OP_JALR = 3'b101,
    OP_HALT = 3'b110,
    OP_NOOP = 3'b111
  } opcode_e;

  localparam int OPCODE_HI = 24;
  localparam int OPCODE_LO = 22;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } fetchState_e;

  function automatic logic [2:0] opcodeOf(input logic [31:0] word);
    return word[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] count
);

  logic [31:0] countQ;
  logic        atMax;

  assign atMax = &countQ;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countQ <= 32'd0;
    end else if (enable && !atMax) begin
      countQ <= countQ + 32'd1;
    end
  end

  assign count = countQ;

endmodule

// File: rtl/pc_fetch_unit.sv
// LC2K program counter and instruction-fetch sequencer: fetches the word at
// the PC over req/ack, presents it to execute, then loads the next PC.
module pc_fetch_unit
  import lc2k_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter logic [2:0]  HALT_OPCODE = OP_HALT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  input  logic        exec_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_current,
  output logic [31:0] pc_plus_one,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);

  fetchState_e stateQ, stateD;
  logic [31:0] pcQ;
  logic [31:0] instrQ;
  logic        isHalt;
  logic        pcOutOfRange;
  logic        retire;

  assign isHalt = (opcodeOf(instrQ) == HALT_OPCODE);

  // A shift (rather than a part-select) stays legal when ADDR_WIDTH reaches 32.
  assign pcOutOfRange = ((pc_next >> ADDR_WIDTH) != 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= S_IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    stateD = stateQ;
    retire = 1'b0;
    unique case (stateQ)
      S_IDLE:  stateD = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          stateD = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (isHalt) begin
          stateD = S_HALT;
          retire = 1'b1;
        end else if (exec_done) begin
          stateD = pcOutOfRange ? S_FAULT : S_FETCH;
          retire = 1'b1;
        end
      end
      S_HALT, S_FAULT: stateD = stateQ;
      default: stateD = S_IDLE;
    endcase
  end

  // Halt steps the PC past itself; the faulting PC is kept for debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcQ <= RESET_PC;
    end else if (stateQ == S_ISSUE) begin
      if (isHalt) begin
        pcQ <= pcQ + 32'd1;
      end else if (exec_done) begin
        pcQ <= pc_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrQ <= 32'd0;
    end else if (stateQ == S_FETCH && imem_ack) begin
      instrQ <= imem_rdata;
    end
  end

  sat_counter32 uInstrCount (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (retire),
    .count  (instr_count)
  );

  // Status outputs decode straight from state so reset clears them at once.
  assign imem_req    = (stateQ == S_FETCH);
  assign imem_addr   = pcQ;
  assign instr_valid = (stateQ == S_ISSUE);
  assign instr       = instrQ;
  assign pc_current  = pcQ;
  assign pc_plus_one = pcQ + 32'd1;
  assign halted      = (stateQ == S_HALT);
  assign fault       = (stateQ == S_FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: reset, sequential fetch,
// branch, memory wait states, out-of-range fault and counter saturation.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        exec_done;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_current;
  logic [31:0] pc_plus_one;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;

  int total = 0;
  int bad = 0;
  int cycleCount = 0;
  int firstReq = 0;

  pc_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_next     (pc_next),
    .exec_done   (exec_done),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_current  (pc_current),
    .pc_plus_one (pc_plus_one),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b1;
    exec_done  = 1'b0;
    pc_next    = 32'd0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_req",    32'(imem_req),    32'd0);
    check("rst_pc",     pc_current,       32'd0);
    check("rst_count",  instr_count,      32'd0);
    check("rst_instr",  instr,            32'd0);
    check("rst_valid",  32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted),      32'd0);
    check("rst_fault",  32'(fault),       32'd0);

    // Sequential fetch: add, noop, halt with zero-wait memory.
    tick(); rst_n = 1'b1; #1;
    check("idle_req", 32'(imem_req), 32'd0);
    tick();
    check("seq_req0",  32'(imem_req), 32'd1);
    check("seq_addr0", imem_addr,     32'd0);
    firstReq = cycleCount;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
    tick();
    check("seq_valid0", 32'(instr_valid), 32'd1);
    check("seq_reqoff", 32'(imem_req),    32'd0);
    check("seq_ppo0",   pc_plus_one,      32'd1);
    imem_ack = 1'b0; exec_done = 1'b1; pc_next = 32'd1;
    tick();
    check("seq_addr1",  imem_addr,        32'd1);
    check("seq_count1", instr_count,      32'd1);
    exec_done = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h01C0_0000;
    tick();
    check("seq_instr1", instr, 32'h01C0_0000);
    imem_ack = 1'b0; exec_done = 1'b1; pc_next = 32'd2;
    tick();
    check("seq_addr2",  imem_addr,   32'd2);
    check("seq_count2", instr_count, 32'd2);
    exec_done = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0180_0000;
    tick();
    check("seq_haltissue", 32'(halted), 32'd0);
    check("seq_instr2",    instr,       32'h0180_0000);
    imem_ack = 1'b0;
    tick();
    check("halt_flag",   32'(halted),      32'd1);
    check("halt_pc",     pc_current,       32'd3);
    check("halt_count",  instr_count,      32'd3);
    check("halt_valid",  32'(instr_valid), 32'd0);
    check("halt_req",    32'(imem_req),    32'd0);
    check("halt_cycles", 32'(cycleCount - firstReq), 32'd6);
    exec_done = 1'b1; pc_next = 32'd9; imem_ack = 1'b1;
    tick();
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_pchold", pc_current,  32'd3);
    exec_done = 1'b0; imem_ack = 1'b0;

    // Reset out of HALT, then branch from pc=5 to 20.
    rst_n = 1'b0; #1;
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_pc",     pc_current,  32'd0);
    tick(); rst_n = 1'b1;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h01C0_0000;
    tick();
    imem_ack = 1'b0; exec_done = 1'b1; pc_next = 32'd5;
    tick();
    check("br_addr5", imem_addr, 32'd5);
    exec_done = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
    tick();
    check("br_ppo6", pc_plus_one, 32'd6);
    imem_ack = 1'b0; exec_done = 1'b1; pc_next = 32'd20;
    tick();
    exec_done = 1'b0; imem_rdata = 32'hDEAD_BEEF;

    // Three wait cycles, ack on the fourth request cycle.
    for (int w = 0; w < 4; w++) begin
      check("wait_req",   32'(imem_req), 32'd1);
      check("wait_addr",  imem_addr,     32'd20);
      check("wait_instr", instr,         32'h0000_0000);
      if (w == 3) begin
        imem_ack = 1'b1; imem_rdata = 32'h0081_0003;
      end
      tick();
    end
    check("wait_capture", instr,            32'h0081_0003);
    check("br_ppo21",     pc_plus_one,      32'd21);
    check("wait_valid",   32'(instr_valid), 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    check("spur_instr", instr,            32'h0081_0003);
    check("spur_valid", 32'(instr_valid), 32'd1);
    imem_ack = 1'b0; exec_done = 1'b1; pc_next = 32'd21;
    tick();
    check("mid_req",   32'(imem_req), 32'd1);
    check("mid_count", instr_count,   32'd3);
    exec_done = 1'b0;

    // Reset while a fetch is outstanding; a late ack in IDLE is ignored.
    rst_n = 1'b0; #1;
    check("mrst_req",   32'(imem_req), 32'd0);
    check("mrst_pc",    pc_current,    32'd0);
    check("mrst_count", instr_count,   32'd0);
    check("mrst_instr", instr,         32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0180_0000;
    tick(); rst_n = 1'b1;
    tick();
    check("late_req",   32'(imem_req), 32'd1);
    check("late_addr",  imem_addr,     32'd0);
    check("late_instr", instr,         32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0000;

    // Out-of-range PC: 0xFFFF is the last legal address.
    tick();
    imem_ack = 1'b0; exec_done = 1'b1; pc_next = 32'h0000_FFFF;
    tick();
    check("edge_fault", 32'(fault), 32'd0);
    check("edge_addr",  imem_addr,  32'h0000_FFFF);
    exec_done = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0; exec_done = 1'b1; pc_next = 32'h0001_0000;
    tick();
    check("flt_flag",  32'(fault),       32'd1);
    check("flt_pc",    pc_current,       32'h0001_0000);
    check("flt_req",   32'(imem_req),    32'd0);
    check("flt_valid", 32'(instr_valid), 32'd0);
    check("flt_count", instr_count,      32'd2);
    pc_next = 32'd7; imem_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("flt_hold_pc",    pc_current,    32'h0001_0000);
      check("flt_hold_count", instr_count,   32'd2);
      check("flt_hold_req",   32'(imem_req), 32'd0);
      check("flt_hold_flag",  32'(fault),    32'd1);
    end
    exec_done = 1'b0; imem_ack = 1'b0;

    // Counter saturation.
    rst_n = 1'b0; #1;
    tick(); rst_n = 1'b1;
    tick();
    force dut.uInstrCount.countQ = 32'hFFFF_FFFE;
    #1 release dut.uInstrCount.countQ;
    #1;
    check("sat_preset", instr_count, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1'b1; imem_rdata = 32'h01C0_0000;
      tick();
      imem_ack = 1'b0; exec_done = 1'b1; pc_next = 32'(k + 1);
      tick();
      exec_done = 1'b0;
      check("sat_count", instr_count, 32'hFFFF_FFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
